// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the pipeline
// registers it controls.
// Contents: controller state encoding, NOP instruction word used for bubbles.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_ctrl_state_t;

  // Instruction word loaded into a pipeline register when it is bubbled or
  // flushed (addi x0, x0, 0): decodes with every write/memory enable low.
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter for performance debug.
// Ports: clk, rst (sync, active-high), inc (count this cycle), count (value).
// Holds at all-ones once reached; never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges hazard, taken-branch and MEM-stage
// SRAM wait into freeze/bubble/flush controls, with a sticky memory watchdog.
// Ports: hazard/branch_taken/mem_req/mem_ready in; freeze/bubble/flush
// controls (combinational, zero latency), mem_timeout, stall/flush counters out.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  // wait_cnt holds (stalled cycles so far - 1) during MEM_WAIT, so this value
  // marks the last tolerated stall cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  pipe_ctrl_state_t  state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_stall;

  assign mem_stall   = mem_req & ~mem_ready;
  assign mem_timeout = (state == ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    freeze_pc   = 1'b0;
    freeze_ifid = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    freeze_pipe = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERROR;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      ERROR: begin
        // Locked until reset.
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase

    // Priority: error lock, memory stall, taken branch, data hazard.
    // A branch or hazard seen under a memory stall is dropped here; the
    // frozen stages present it again once the stall clears.
    if (rst) begin
      // all controls held low during reset
    end else if (state == ERROR) begin
      freeze_pc   = 1'b1;
      freeze_ifid = 1'b1;
      freeze_pipe = 1'b1;
    end else if (mem_stall) begin
      freeze_pc   = 1'b1;
      freeze_ifid = 1'b1;
      freeze_pipe = 1'b1;
    end else if (branch_taken) begin
      // ID instruction is being killed, so any hazard on it is irrelevant.
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (hazard) begin
      freeze_pc   = 1'b1;
      freeze_ifid = 1'b1;
      bubble_idex = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_pc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_ifid),
    .count (flush_count)
  );

endmodule
